// File: rtl/l3_shared_responder.sv
// rtl/l3_shared_responder.sv - four-core shared L3 responder with a direct-mapped cache over a 256-byte store
module l3_shared_responder #(
    parameter int MISS_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_rd,
    input  logic [3:0]  req_wr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rsp_rdata,
    output logic [3:0]  rsp_valid,
    output logic [3:0]  rsp_ready,
    output logic [7:0]  hit_count,
    output logic [7:0]  miss_count
);
    typedef enum logic [1:0] {IDLE, LOOKUP, MISS_WAIT, RESPOND} state_e;

    state_e      state_q, state_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] valid_q, valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  hit_q, hit_d;
    logic [7:0]  miss_q, miss_d;

    // Backing store and cache payload are not reset; only the valid bits are.
    logic [7:0]  mem_q [256];
    logic [7:0]  line_data_q [16];
    logic [3:0]  line_tag_q [16];

    logic [3:0]  pending;
    logic [3:0]  idx;
    logic [3:0]  tag;
    logic        tag_hit;
    logic        mem_we;
    logic        line_wr;
    logic        line_fill;
    logic        found;
    logic [1:0]  cand;
    logic [1:0]  sel;

    assign pending    = req_rd | req_wr;
    assign idx        = addr_q[3:0];
    assign tag        = addr_q[7:4];
    assign tag_hit    = valid_q[idx] && (line_tag_q[idx] == tag);
    assign rsp_rdata  = rdata_q;
    assign rsp_ready  = (state_q == IDLE) ? 4'hF : 4'h0;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

    // Round-robin pick: first pending core after the last one served.
    always_comb begin
        found = 1'b0;
        sel   = last_grant_q;
        cand  = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant_q + 2'(k);
            if (!found && pending[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Completion pulse goes only to the core being served.
    always_comb begin
        rsp_valid = '0;
        if (state_q == RESPOND) begin
            rsp_valid[gnt_q] = 1'b1;
        end
    end

    // Next-state and datapath control for the single-transaction FSM.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_d         = wr_q;
        cnt_d        = cnt_q;
        valid_d      = valid_q;
        rdata_d      = rdata_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        mem_we       = 1'b0;
        line_wr      = 1'b0;
        line_fill    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d        = sel;
                    last_grant_d = sel;
                    addr_d       = req_addr[{sel, 3'b000} +: 8];
                    wdata_d      = req_wdata[{sel, 3'b000} +: 8];
                    wr_d         = req_wr[sel];
                    state_d      = LOOKUP;
                end
            end
            LOOKUP: begin
                if (wr_q) begin
                    mem_we  = 1'b1;
                    line_wr = tag_hit;
                    state_d = RESPOND;
                end else if (tag_hit) begin
                    rdata_d[{gnt_q, 3'b000} +: 8] = line_data_q[idx];
                    if (hit_q != 8'hFF) begin
                        hit_d = hit_q + 8'd1;
                    end
                    state_d = RESPOND;
                end else begin
                    cnt_d = 4'(MISS_LATENCY - 1);
                    if (miss_q != 8'hFF) begin
                        miss_d = miss_q + 8'd1;
                    end
                    state_d = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (cnt_q == 4'd0) begin
                    line_fill    = 1'b1;
                    valid_d[idx] = 1'b1;
                    rdata_d[{gnt_q, 3'b000} +: 8] = mem_q[addr_q];
                    state_d      = RESPOND;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and status registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 2'd3;
            gnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
            cnt_q        <= '0;
            valid_q      <= '0;
            rdata_q      <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            rdata_q      <= rdata_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    // Storage writes: write-through to the store, line update on write hit, line fill on miss.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
        if (line_wr) begin
            line_data_q[idx] <= wdata_q;
        end
        if (line_fill) begin
            line_data_q[idx] <= mem_q[addr_q];
            line_tag_q[idx]  <= tag;
        end
    end
endmodule

// File: tb/tb_l3_shared_responder.sv
// tb/tb_l3_shared_responder.sv - randomized self-checking bench with a transaction-timeline reference model
module tb_l3_shared_responder;
    localparam int ML = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_rd = '0;
    logic [3:0]  req_wr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] rsp_rdata;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [7:0]  hit_count;
    logic [7:0]  miss_count;

    l3_shared_responder #(.MISS_LATENCY(ML)) dut (
        .clk(clk), .rst_n(rst_n), .req_addr(req_addr), .req_rd(req_rd), .req_wr(req_wr),
        .req_wdata(req_wdata), .rsp_rdata(rsp_rdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         wr;
        bit         both;
        logic [7:0] a;
        logic [7:0] d;
    } op_t;

    // reference model: store contents, cache directory, counters, per-core read data
    logic [7:0] mem_m [256];
    bit         mem_known [256];
    bit         vld_m [16];
    logic [3:0] tag_m [16];
    logic [7:0] rd_m [4];
    bit         rd_known [4];
    logic [7:0] hit_m, miss_m;
    int         last_m;

    // transaction timeline and per-core request drivers
    op_t opq [4][$];
    op_t cur [4];
    bit  act [4];
    int  drop_at [4];
    bit  inflight;
    int  resp_cyc, resp_core, free_cyc, cyc;
    bit  gaps;
    int  resp_order [$];

    int n_total = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_pins();
        for (int i = 0; i < 4; i++) begin
            req_wr[i]           = act[i] && cur[i].wr;
            req_rd[i]           = act[i] && (!cur[i].wr || cur[i].both);
            req_addr[i*8 +: 8]  = act[i] ? cur[i].a : 8'h00;
            req_wdata[i*8 +: 8] = act[i] ? cur[i].d : 8'h00;
        end
    endtask

    task automatic push_op(input int c, input bit wr, input logic [7:0] a, input logic [7:0] d, input bit both);
        op_t o;
        o.wr = wr; o.both = both; o.a = a; o.d = d;
        opq[c].push_back(o);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) vld_m[i] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_m[i] = 8'h00; rd_known[i] = 1'b1; act[i] = 1'b0; drop_at[i] = -1;
            opq[i].delete();
        end
        hit_m = 8'h00; miss_m = 8'h00; last_m = 3;
        inflight = 1'b0; free_cyc = cyc;
        drive_pins();
    endtask

    // Apply one transaction's effect and schedule its completion cycle.
    task automatic grant_model(input int c);
        op_t o;
        int lat;
        o = cur[c];
        if (o.wr) begin
            mem_m[o.a] = o.d; mem_known[o.a] = 1'b1; lat = 2;
        end else if (vld_m[o.a[3:0]] && tag_m[o.a[3:0]] == o.a[7:4]) begin
            lat = 2;
            if (hit_m != 8'hFF) hit_m++;
            rd_m[c] = mem_m[o.a]; rd_known[c] = mem_known[o.a];
        end else begin
            lat = 2 + ML;
            if (miss_m != 8'hFF) miss_m++;
            vld_m[o.a[3:0]] = 1'b1; tag_m[o.a[3:0]] = o.a[7:4];
            rd_m[c] = mem_m[o.a]; rd_known[c] = mem_known[o.a];
        end
        last_m = c; inflight = 1'b1; resp_core = c;
        resp_cyc = cyc + lat; free_cyc = cyc + lat + 1;
    endtask

    task automatic step();
        logic [3:0] exp_v;
        bit granted;
        int c;
        @(posedge clk);
        #1;
        cyc++;
        exp_v = (inflight && resp_cyc == cyc) ? (4'b0001 << resp_core) : 4'b0000;
        check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        check_eq("rsp_ready", 32'(rsp_ready), (!inflight && cyc >= free_cyc) ? 32'hF : 32'h0);
        if (exp_v != 4'b0000) begin
            check_eq("hit_count", 32'(hit_count), 32'(hit_m));
            check_eq("miss_count", 32'(miss_count), 32'(miss_m));
            for (int i = 0; i < 4; i++)
                if (rd_known[i]) check_eq("rsp_rdata", 32'(rsp_rdata[i*8 +: 8]), 32'(rd_m[i]));
            resp_order.push_back(resp_core);
            drop_at[resp_core] = cyc + 1;
            inflight = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (act[i] && drop_at[i] == cyc) begin
                act[i] = 1'b0;
            end else if (!act[i] && drop_at[i] < cyc && opq[i].size() > 0 &&
                         (!gaps || $urandom_range(0, 1) == 1)) begin
                cur[i] = opq[i].pop_front();
                act[i] = 1'b1;
            end
        end
        drive_pins();
        if (!inflight && cyc >= free_cyc) begin
            granted = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                c = (last_m + k) % 4;
                if (!granted && act[c]) begin
                    granted = 1'b1;
                    grant_model(c);
                end
            end
        end
    endtask

    function automatic bit busy();
        bit b;
        b = inflight;
        for (int i = 0; i < 4; i++) b = b || act[i] || (opq[i].size() > 0);
        return b;
    endfunction

    task automatic run_all(input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        check_eq("drain_busy", 32'(busy()), 32'h0);
    endtask

    // Full reset taken at a cycle boundary, released one edge later.
    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] a;
        bit reached;
        cyc = 0; gaps = 1'b0;
        for (int i = 0; i < 256; i++) begin mem_m[i] = 8'h00; mem_known[i] = 1'b0; end
        for (int i = 0; i < 16; i++) tag_m[i] = 4'h0;
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_valid", 32'(rsp_valid), 32'h0);
        check_eq("rst_ready", 32'(rsp_ready), 32'hF);
        check_eq("rst_hit", 32'(hit_count), 32'h0);
        check_eq("rst_miss", 32'(miss_count), 32'h0);
        check_eq("rst_rdata", rsp_rdata, 32'h0);
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;

        // write, miss then hit on the same address by core 0
        push_op(0, 1'b1, 8'h15, 8'h2A, 1'b0);
        push_op(0, 1'b0, 8'h15, 8'h00, 1'b0);
        push_op(0, 1'b0, 8'h15, 8'h00, 1'b0);
        run_all(200);
        check_eq("c0_rdata", 32'(rsp_rdata[7:0]), 32'h2A);
        check_eq("miss_1", 32'(miss_count), 32'd1);
        check_eq("hit_1", 32'(hit_count), 32'd1);

        // conflicting index 5 evicts 0x15
        push_op(1, 1'b1, 8'h25, 8'h33, 1'b0);
        push_op(1, 1'b0, 8'h25, 8'h00, 1'b0);
        run_all(200);
        push_op(0, 1'b0, 8'h15, 8'h00, 1'b0);
        run_all(200);
        check_eq("c1_rdata", 32'(rsp_rdata[15:8]), 32'h33);
        check_eq("miss_3", 32'(miss_count), 32'd3);

        // write hit updates the cached line
        push_op(3, 1'b1, 8'h15, 8'h7E, 1'b1);
        push_op(3, 1'b0, 8'h15, 8'h00, 1'b0);
        run_all(200);
        check_eq("c3_rdata", 32'(rsp_rdata[31:24]), 32'h7E);
        check_eq("miss_still_3", 32'(miss_count), 32'd3);
        check_eq("hit_2", 32'(hit_count), 32'd2);

        // reset in the middle of a miss wait
        push_op(0, 1'b0, 8'h40, 8'h00, 1'b0);
        reached = 1'b0;
        for (int n = 0; n < 50 && !reached; n++) begin
            step();
            if (inflight && resp_cyc - cyc == 2) reached = 1'b1;
        end
        check_eq("reach_miss_wait", 32'(reached), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(rsp_valid), 32'h0);
        check_eq("mid_rst_ready", 32'(rsp_ready), 32'hF);
        check_eq("mid_rst_hit", 32'(hit_count), 32'h0);
        check_eq("mid_rst_miss", 32'(miss_count), 32'h0);
        check_eq("mid_rst_rdata", rsp_rdata, 32'h0);
        @(posedge clk);
        #1;
        cyc++;
        model_reset();
        rst_n = 1'b1;
        push_op(0, 1'b0, 8'h40, 8'h00, 1'b0);
        run_all(200);
        check_eq("miss_after_rst", 32'(miss_count), 32'd1);

        // all four cores at once, then cores 0 and 2 together
        do_reset();
        resp_order.delete();
        for (int i = 0; i < 4; i++) push_op(i, 1'b1, 8'(8'h80 + i), 8'(8'hA0 + i), 1'b0);
        run_all(200);
        push_op(0, 1'b0, 8'h80, 8'h00, 1'b0);
        push_op(2, 1'b1, 8'h90, 8'h5C, 1'b0);
        run_all(200);
        check_eq("order_n", 32'(resp_order.size()), 32'd6);
        if (resp_order.size() == 6) begin
            for (int i = 0; i < 4; i++) check_eq("order_all4", 32'(resp_order[i]), 32'(i));
            check_eq("order_pair0", 32'(resp_order[4]), 32'd0);
            check_eq("order_pair2", 32'(resp_order[5]), 32'd2);
        end

        // randomized mixed traffic on a conflict-heavy address pool
        gaps = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 255));
            else a = {2'b00, 2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3))};
            push_op($urandom_range(0, 3), $urandom_range(0, 2) == 0, a,
                    8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
        end
        run_all(30000);

        // drive both counters into saturation
        gaps = 1'b0;
        for (int n = 0; n < 270; n++) begin
            push_op(2, 1'b0, 8'h15, 8'h00, 1'b0);
            push_op(1, 1'b0, (n % 2 == 0) ? 8'h16 : 8'h26, 8'h00, 1'b0);
        end
        run_all(20000);
        check_eq("hit_sat", 32'(hit_count), 32'hFF);
        check_eq("miss_sat", 32'(miss_count), 32'hFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
